// File: rtl/id_counter.sv
// rtl/id_counter.sv - ADPLL increment/decrement counter with divide-by-N output stage
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   inc     - carry request pulse from the K-counter (insert a cycle-shortening)
//   dec     - borrow request pulse from the K-counter (insert a cycle-lengthening)
//   id_out  - phase-adjusted pulse train, nominally 1100 repeating
//   div_out - id_out periods divided by N, square wave
//   pend    - signed pending-request count, positive means inserts are owed
//   ovf     - one-cycle pulse when a request is dropped at saturation

module id_counter #(
    parameter int N        = 8,
    parameter int PEND_MAX = 3,
    parameter int PW       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic                 id_out,
    output logic                 div_out,
    output logic signed [PW-1:0] pend,
    output logic                 ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic signed [PW-1:0] PMAX  = PW'(PEND_MAX);
    localparam logic signed [PW-1:0] PMIN  = PW'(-PEND_MAX);
    localparam logic signed [PW-1:0] ONE   = PW'(1);
    localparam logic signed [PW-1:0] MONE  = PW'(-1);
    localparam logic signed [PW-1:0] ZERO  = '0;
    localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]        CNT_HALF = CW'(N / 2);

    typedef enum logic [2:0] {
        S0  = 3'd0,
        S1  = 3'd1,
        S2  = 3'd2,
        S3  = 3'd3,
        S3X = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 id_q, id_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic signed [PW-1:0] pend_q, pend_d;
    logic                 ovf_q, ovf_d;

    logic signed [PW-1:0] consume;
    logic signed [PW-1:0] pend_base;
    logic                 period_start;

    always_comb begin
        state_d = state_q;
        consume = ZERO;
        case (state_q)
            S0:  state_d = S1;
            S1:  state_d = S2;
            S2: begin
                // Decision uses the registered count: at most one request per period.
                if (pend_q > ZERO) begin
                    state_d = S0;
                    consume = ONE;
                end else if (pend_q < ZERO) begin
                    state_d = S3X;
                    consume = MONE;
                end else begin
                    state_d = S3;
                end
            end
            S3X: state_d = S3;
            S3:  state_d = S0;
            default: state_d = S3;
        endcase
    end

    // Consumption is applied before the new request so a request arriving on
    // the consuming edge can use the room it frees.
    always_comb begin
        pend_base = pend_q - consume;
        pend_d    = pend_base;
        ovf_d     = 1'b0;
        if (inc && !dec) begin
            if (pend_base >= PMAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_base + ONE;
            end
        end else if (dec && !inc) begin
            if (pend_base <= PMIN) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_base - ONE;
            end
        end
    end

    // The divider only advances on entry into S0, i.e. once per id_out period.
    always_comb begin
        period_start = (state_d == S0);
        id_d         = (state_d == S0) || (state_d == S1);
        cnt_d        = cnt_q;
        div_d        = div_q;
        if (period_start) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            div_d = (cnt_d < CNT_HALF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S3;
            id_q    <= 1'b0;
            cnt_q   <= CNT_LAST;
            div_q   <= 1'b0;
            pend_q  <= ZERO;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign id_out  = id_q;
    assign div_out = div_q;
    assign pend    = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_id_counter.sv
// tb/tb_id_counter.sv - directed self-checking bench for id_counter

module tb_id_counter;

    logic              clk;
    logic              rst_n;
    logic              inc;
    logic              dec;
    logic              id_out;
    logic              div_out;
    logic signed [2:0] pend;
    logic              ovf;

    int n_checks;
    int n_errors;

    logic [63:0]       id_v;
    logic [63:0]       div_v;
    logic [63:0]       ovf_v;
    logic signed [2:0] pend_h [64];

    id_counter #(.N(8), .PEND_MAX(3), .PW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .id_out  (id_out),
        .div_out (div_out),
        .pend    (pend),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies n cycles of inc/dec (first cycle in the MSB of the n-bit field)
    // starting from a negedge, and records outputs after each posedge.
    task automatic run(input int n, input logic [63:0] inc_v, input logic [63:0] dec_v);
        id_v  = '0;
        div_v = '0;
        ovf_v = '0;
        for (int k = 0; k < n; k++) begin
            inc = inc_v[n-1-k];
            dec = dec_v[n-1-k];
            @(negedge clk);
            id_v      = {id_v[62:0], id_out};
            div_v     = {div_v[62:0], div_out};
            ovf_v     = {ovf_v[62:0], ovf};
            pend_h[k] = pend;
        end
        inc = 1'b0;
        dec = 1'b0;
    endtask

    initial begin
        int nz;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_id",   longint'(id_out),  0);
        check("rst_div",  longint'(div_out), 0);
        check("rst_pend", longint'(pend),    0);
        check("rst_ovf",  longint'(ovf),     0);

        // Idle: edges 1..64
        rst_n = 1'b1;
        run(64, 64'h0, 64'h0);
        check("idle_id",  longint'(id_v),  longint'(64'hCCCC_CCCC_CCCC_CCCC));
        check("idle_div", longint'(div_v), longint'(64'hFFFF_0000_FFFF_0000));
        check("idle_ovf", longint'(ovf_v), 0);
        nz = 0;
        for (int k = 0; k < 64; k++) if (pend_h[k] != 3'sd0) nz++;
        check("idle_pend", nz, 0);

        // Single inc sampled while in S0: edges 65..80
        run(16, 64'h4000, 64'h0);
        check("inc_id",    longint'(id_v),  longint'(64'hD999));
        check("inc_div",   longint'(div_v), longint'(64'hFFFE));
        check("inc_pend1", longint'(pend_h[1]), 1);
        check("inc_pend2", longint'(pend_h[2]), 1);
        check("inc_pend3", longint'(pend_h[3]), 0);
        check("inc_ovf",   longint'(ovf_v), 0);

        // Single dec sampled while in S0: edges 81..96
        run(16, 64'h0, 64'h8000);
        check("dec_id",    longint'(id_v),  longint'(64'h8CCC));
        check("dec_div",   longint'(div_v), 0);
        check("dec_pend0", longint'(pend_h[0]), -1);
        check("dec_pend1", longint'(pend_h[1]), -1);
        check("dec_pend2", longint'(pend_h[2]), 0);
        run(1, 64'h0, 64'h0);
        check("dec_div_rise", longint'(div_v), 1);
        check("dec_id_97",    longint'(id_v),  1);

        // Saturation: reach S3 (edge 100), then inc held for edges 101..105
        run(3, 64'h0, 64'h0);
        run(16, 64'hF800, 64'h0);
        check("sat_id",    longint'(id_v),  longint'(64'hDB6C));
        check("sat_ovf",   longint'(ovf_v), longint'(64'h0800));
        check("sat_p0",    longint'(pend_h[0]),  1);
        check("sat_p2",    longint'(pend_h[2]),  3);
        check("sat_p3",    longint'(pend_h[3]),  3);
        check("sat_p4",    longint'(pend_h[4]),  3);
        check("sat_p6",    longint'(pend_h[6]),  2);
        check("sat_p9",    longint'(pend_h[9]),  1);
        check("sat_p12",   longint'(pend_h[12]), 0);

        // Simultaneous inc+dec: edges 117..132
        run(16, 64'hA410, 64'hA410);
        check("sim_id",  longint'(id_v),  longint'(64'hCCCC));
        check("sim_ovf", longint'(ovf_v), 0);
        nz = 0;
        for (int k = 0; k < 16; k++) if (pend_h[k] != 3'sd0) nz++;
        check("sim_pend", nz, 0);

        // Reset mid-S1 with pend=2
        run(2, 64'h3, 64'h0);
        check("pre_rst_pend", longint'(pend),    2);
        check("pre_rst_id",   longint'(id_out),  1);
        check("pre_rst_div",  longint'(div_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_id",   longint'(id_out),  0);
        check("async_div",  longint'(div_out), 0);
        check("async_pend", longint'(pend),    0);
        check("async_ovf",  longint'(ovf),     0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(8, 64'h0, 64'h0);
        check("restart_id",  longint'(id_v),  longint'(64'hCC));
        check("restart_div", longint'(div_v), longint'(64'hFF));
        nz = 0;
        for (int k = 0; k < 8; k++) if (pend_h[k] != 3'sd0) nz++;
        check("restart_pend", nz, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_counter.md
Name: id_counter

Overview:
- Increment/decrement (ID) counter and output divider stage of the ADPLL, the consumer of the K-counter's carry (inc) and borrow (dec) pulses.
- Generates a nominal clk/4 pulse train and shifts its phase by one clk cycle per accepted request: inc shortens one period, dec lengthens one period.
- A divide-by-N stage produces the recovered clock fed back to the phase detector.

Parameters:
N, 8, divide ratio of the id_out to div_out stage; even and at least 2.
PEND_MAX, 3, saturation limit (±) of the pending-request accumulator.
PW, 3, width of the signed pending accumulator; must hold ±PEND_MAX.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
inc  input  1  carry request from the K-counter; one-cycle pulse, synchronous to clk.
dec  input  1  borrow request from the K-counter; one-cycle pulse, synchronous to clk.
id_out  output  1  phase-adjusted pulse train, nominally 1100 repeating.
div_out  output  1  id_out periods divided by N; square wave.
pend  output  PW  signed pending-request count; positive means inserts are owed.
ovf  output  1  one-cycle pulse when a request is dropped at saturation.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state updates on posedge clk.
- Reset values: state=S3, id_out=0, div_cnt=N-1, div_out=0, pend=0, ovf=0. Reset mid-operation aborts immediately and discards pending requests.
- State machine:
  - States S0, S1, S2, S3, S3X.
  - id_out is registered and equals 1 in S0 and S1, 0 otherwise.
- Transitions:
  - S0→S1.
  - S1→S2.
  - S2 with pend>0 → S0 (insert; 3-cycle period); pend decrements.
  - S2 with pend<0 → S3X (delete); pend increments.
  - S2 with pend==0 → S3.
  - S3X→S3.
  - S3→S0.
- Period lengths: nominal 4 cycles (1100), insert 3 cycles (110), delete 5 cycles (11000).
- Service rate: at most one request per id_out period. The S2 decision uses the registered pend, i.e. requests latched by the previous edge.
- Pend update each edge: pend_next = pend + inc - dec - consume, where consume is +1 on insert, -1 on delete, else 0.
  - inc and dec in the same cycle cancel: net 0, no ovf.
  - If inc would push pend above +PEND_MAX, or dec below -PEND_MAX, that request is dropped and ovf=1 for that cycle only. Consumption is applied first, so a request arriving on the consuming edge is never dropped when the consumption makes room.
- Divider:
  - A "period start" is any transition into S0.
  - On each period start, div_cnt wraps N-1→0, otherwise increments.
  - On the same edge, div_out <= (new div_cnt < N/2). div_out is therefore high for N/2 id_out periods, then low for N/2.
  - div_out and div_cnt are unchanged on all other edges.
  - The first edge after reset release enters S0, so id_out=1, div_cnt=0 and div_out=1 on that same edge.
- Arithmetic: pend is two's complement PW bits; all comparisons are signed. div_cnt is ceil(log2 N) bits, unsigned.
- No combinational path from inputs to outputs; every output is registered.

Test Plan:
- Idle: release rst_n, no inc/dec for 64 cycles → id_out pattern 1100 repeating from the first edge; div_out high 16 cycles, low 16 cycles; pend=0, ovf=0 throughout.
- Single inc: pulse inc one cycle while in S0 → pend=1 next edge; following S2 goes to S0, giving a 3-cycle period (110); pend=0; afterwards nominal 4-cycle periods; div_out edges advanced by 1 cycle.
- Single dec: pulse dec while in S0 → pend=-1; that period is 11000 (5 cycles); pend returns to 0; div_out edges retarded by 1 cycle.
- Saturation: hold inc high for 5 consecutive cycles starting in S3 → pend reaches +3; ovf pulses on the over-limit cycles except where an S2 consume makes room; then three consecutive 3-cycle periods bring pend to 0.
- Simultaneous: inc=dec=1 in the same cycle, repeated 4 times → pend stays 0, ovf=0, id_out strictly 4-cycle periodic.
- Reset mid-operation: with pend=2, assert rst_n low mid-S1 → id_out, div_out, pend and ovf go to 0 asynchronously without waiting for clk; after release, sequence restarts at S0 with pend=0.
